// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative radix-2 RV32M multiply/divide with RF writeback  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] OP1,
   input  logic [XLEN-1:0] OP2,
   input  logic [4:0]      RD_in,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic            wr_en_RF,
   output logic [4:0]      RD,
   output logic [XLEN-1:0] Data_In_RF
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [2:0]      op;
   logic [4:0]      rd_lat;
   logic [XLEN-1:0] opa, hi, lo;
   logic            neg_res, neg_rem;
   logic [CW-1:0]   count;
   logic            done_q, wr_q;

   logic            signed1, signed2, neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] special_res;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [XLEN-1:0] hi_nxt, lo_nxt;
   logic [2*XLEN-1:0] prod, prod_c;
   logic [XLEN-1:0] result;

   // Operand decode at issue: magnitudes, sign flags and the short-circuit cases.
   always_comb begin
      signed1  = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
      signed2  = funct3 inside {3'b001, 3'b100, 3'b110};
      neg1     = signed1 && OP1[XLEN-1];
      neg2     = signed2 && OP2[XLEN-1];
      mag1     = neg1 ? -OP1 : OP1;
      mag2     = neg2 ? -OP2 : OP2;
      div_zero = funct3[2] && (OP2 == '0);
      div_ovf  = funct3[2] && !funct3[0] && (OP1 == {1'b1, {(XLEN-1){1'b0}}}) && (OP2 == '1);
      special  = div_zero || div_ovf;
      if (div_zero)
         special_res = funct3[1] ? OP1 : '1;
      else
         special_res = funct3[1] ? '0 : OP1;
   end

   // One iteration: shift-add multiply in {hi,lo}, or restoring divide with hi as remainder.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opa};
      if (op[2]) begin
         hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
         lo_nxt = {lo[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   always_comb begin
      prod   = {hi, lo};
      prod_c = neg_res ? -prod : prod;
      case (op)
         3'b000:                 result = prod_c[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result = prod_c[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result = neg_res ? -lo : lo;
         default:                result = neg_rem ? -hi : hi;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         op         <= '0;
         rd_lat     <= '0;
         opa        <= '0;
         hi         <= '0;
         lo         <= '0;
         neg_res    <= 1'b0;
         neg_rem    <= 1'b0;
         count      <= '0;
         done_q     <= 1'b0;
         wr_q       <= 1'b0;
         RD         <= '0;
         Data_In_RF <= '0;
      end else begin
         done_q <= 1'b0;
         wr_q   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  op      <= funct3;
                  rd_lat  <= RD_in;
                  neg_res <= neg1 ^ neg2;
                  neg_rem <= neg1;
                  count   <= '0;
                  hi      <= '0;
                  if (special) begin
                     Data_In_RF <= special_res;
                     RD         <= RD_in;
                     done_q     <= 1'b1;
                     wr_q       <= (RD_in != 5'd0);
                     state      <= S_DONE;
                  end else begin
                     // Multiply: lo holds the multiplier; divide: lo holds the dividend.
                     opa   <= funct3[2] ? mag2 : mag1;
                     lo    <= funct3[2] ? mag1 : mag2;
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
               end else if (count == CW'(XLEN)) begin
                  Data_In_RF <= result;
                  RD         <= rd_lat;
                  done_q     <= 1'b1;
                  wr_q       <= (rd_lat != 5'd0);
                  state      <= S_DONE;
               end else begin
                  hi    <= hi_nxt;
                  lo    <= lo_nxt;
                  count <= count + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state != S_IDLE);
   assign done     = done_q;
   assign wr_en_RF = wr_q && !flush;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit : directed table, hazard sequences and random vs model    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n, start, flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] OP1, OP2;
   logic [4:0]      RD_in;
   logic            busy, done, wr_en_RF;
   logic [4:0]      RD;
   logic [XLEN-1:0] Data_In_RF;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] last_exp = '0;
   logic [4:0]  last_rd = '0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
      .OP1(OP1), .OP2(OP2), .RD_in(RD_in), .flush(flush),
      .busy(busy), .done(done), .wr_en_RF(wr_en_RF), .RD(RD),
      .Data_In_RF(Data_In_RF)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   // Reference: RV32M semantics straight from arithmetic on wide integers.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      bit ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'($signed(a) / $signed(b));
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   // Called at a negedge while IDLE; returns just after the accept edge.
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      funct3 = f; OP1 = a; OP2 = b; RD_in = rd; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // lat = negedges after the accept edge until done is seen; 0 on timeout.
   task automatic wait_done(input string nm, output int lat);
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            return;
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done, want done within 60 cycles", nm);
   endtask

   task automatic check_wb(input string nm, input logic [4:0] rd, input logic [31:0] exp,
                           input int lat, input int exp_lat);
      chk($sformatf("%s_latency", nm), 32'(lat), 32'(exp_lat));
      chk1($sformatf("%s_wr_en", nm), wr_en_RF, rd != 5'd0);
      chk1($sformatf("%s_busy", nm), busy, 1'b1);
      chk($sformatf("%s_rd", nm), {27'b0, RD}, {27'b0, rd});
      chk($sformatf("%s_data", nm), Data_In_RF, exp);
      last_exp = exp;
      last_rd  = rd;
   endtask

   task automatic post_chk(input string nm);
      @(negedge clk);
      chk1($sformatf("%s_done_drop", nm), done, 1'b0);
      chk1($sformatf("%s_wr_drop", nm), wr_en_RF, 1'b0);
      chk1($sformatf("%s_idle", nm), busy, 1'b0);
      chk($sformatf("%s_hold", nm), Data_In_RF, last_exp);
   endtask

   task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit special);
      int lat;
      @(negedge clk);
      issue(f, a, b, rd);
      wait_done(nm, lat);
      if (lat > 0) begin
         check_wb(nm, rd, exp, lat, special ? 1 : XLEN + 2);
         post_chk(nm);
      end
   endtask

   task automatic count_dones(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done || wr_en_RF) cnt++;
      end
   endtask

   initial begin
      vec_t tbl[16];
      int lat, cnt;
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      bit          sp;

      tbl[0]  = '{3'd0, 32'd7,         32'd6,         5'd5,  32'h0000_002A, 1'b0};
      tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0};
      tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0};
      tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 1'b0};
      tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0};
      tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0};
      tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        1'b0};
      tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         1'b0};
      tbl[8]  = '{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1'b1};
      tbl[9]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         1'b1};
      tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1};
      tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1'b1};
      tbl[12] = '{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1};
      tbl[13] = '{3'd6, 32'd5,         32'd0,         5'd14, 32'd5,         1'b1};
      tbl[14] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 1'b0};
      tbl[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd31, 32'd1,         1'b0};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = '0; OP1 = '0; OP2 = '0; RD_in = '0;
      repeat (2) @(negedge clk);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_wr_en", wr_en_RF, 1'b0);
      chk("reset_rd", {27'b0, RD}, 32'd0);
      chk("reset_data", Data_In_RF, 32'd0);
      rst_n = 1'b1;

      foreach (tbl[i])
         do_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].special);

      // x0 destination: full run, done pulses, no register-file write.
      do_op("rd_zero", 3'd0, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0);

      // A second start during CALC must be dropped.
      @(negedge clk);
      issue(3'd0, 32'd7, 32'd6, 5'd3);
      repeat (9) @(negedge clk);
      funct3 = 3'd5; OP1 = 32'd1000; OP2 = 32'd3; RD_in = 5'd20; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("mid_start", lat);
      if (lat > 0) begin
         chk("mid_start_data", Data_In_RF, 32'h2A);
         chk("mid_start_rd", {27'b0, RD}, 32'd3);
         last_exp = 32'h2A;
         last_rd  = 5'd3;
      end
      count_dones(45, cnt);
      chk("mid_start_single_wb", 32'(cnt), 32'd0);

      // Flush during CALC: back to IDLE, nothing written, outputs held.
      @(negedge clk);
      issue(3'd5, 32'd1000, 32'd3, 5'd7);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk1("flush_busy", busy, 1'b0);
      chk1("flush_wr_en", wr_en_RF, 1'b0);
      count_dones(45, cnt);
      chk("flush_no_wb", 32'(cnt), 32'd0);
      chk("flush_data_hold", Data_In_RF, last_exp);
      chk("flush_rd_hold", {27'b0, RD}, {27'b0, last_rd});

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk1("arst_busy", busy, 1'b0);
      chk1("arst_done", done, 1'b0);
      chk1("arst_wr_en", wr_en_RF, 1'b0);
      chk("arst_rd", {27'b0, RD}, 32'd0);
      chk("arst_data", Data_In_RF, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      last_exp = '0;
      last_rd  = '0;
      count_dones(45, cnt);
      chk("arst_no_wb", 32'(cnt), 32'd0);

      // Back-to-back: start held through DONE is taken only in the following IDLE cycle.
      @(negedge clk);
      issue(3'd5, 32'd100, 32'd7, 5'd9);
      wait_done("b2b_first", lat);
      if (lat > 0) begin
         check_wb("b2b_first", 5'd9, 32'd14, lat, XLEN + 2);
         funct3 = 3'd7; OP1 = 32'd100; OP2 = 32'd7; RD_in = 5'd10; start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk1("b2b_idle_gap", busy, 1'b0);
         @(posedge clk);
         #1 start = 1'b0;
         wait_done("b2b_second", lat);
         if (lat > 0) begin
            check_wb("b2b_second", 5'd10, 32'd2, lat, XLEN + 2);
            post_chk("b2b_second");
         end
      end

      // Random operations checked against the arithmetic model.
      for (int n = 0; n < 40; n++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'($urandom_range(0, 20));
            default: ;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: ;
         endcase
         rd = 5'($urandom_range(0, 31));
         sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
         do_op($sformatf("rnd%0d_f%0d", n, f), f, a, b, rd, model(f, a, b), sp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
